branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Branch resolution and prediction controller for the pipelined RV32I core. It sits between the EX-stage branch comparator and the PC/pipeline-control logic.
- Decodes branch type and drives the comparator's signed/unsigned select. It turns comparator flags into a taken decision and detects mispredictions, then issues redirect and flush.
- Keeps a direct-mapped table of 2-bit saturating counters, read by IF and updated by EX, plus branch and mispredict statistics counters.

Parameters:
- BHT_DEPTH, 16, number of predictor entries; power of two, 4 to 256.
- IDX_LSB, 2, lowest PC bit used for the index. The index is pc[IDX_LSB +: log2(BHT_DEPTH)].

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous reset, active-high
- i_if_pc  in  32  fetch-stage PC
- o_if_pred_taken  out  1  prediction for i_if_pc; combinational
- i_ex_valid  in  1  EX-stage instruction valid
- i_ex_pc  in  32  EX-stage instruction PC
- i_ex_is_br  in  1  EX instruction is a conditional branch
- i_ex_is_jal  in  1  EX instruction is JAL
- i_ex_is_jalr  in  1  EX instruction is JALR
- i_ex_funct3  in  3  branch funct3
- i_ex_pred_taken  in  1  prediction made in IF, carried down the pipeline
- i_stall  in  1  pipeline stall; EX instruction is held
- i_br_less  in  1  comparator less-than flag
- i_br_equal  in  1  comparator equal flag
- o_br_un  out  1  comparator mode select; 1 = signed, 0 = unsigned
- o_ex_taken  out  1  resolved branch/jump direction
- o_redirect  out  2  00 none, 01 fetch from EX target, 10 fetch from i_ex_pc+4
- o_flush  out  1  kill IF/ID younger instructions
- o_br_count  out  32  resolved conditional branches
- o_mispred_count  out  32  mispredictions, conditional branches only

Behaviour:
- Reset values (asynchronous, at any time, including mid-stall):
  - all table entries = 2'b01 (weakly not-taken)
  - o_br_count = 0, o_mispred_count = 0
  - combinational outputs follow their inputs, with table contents at reset value.
- IF read: o_if_pred_taken = table[idx(i_if_pc)][1]. Zero latency, no bypass. If IF reads an index in the same cycle EX updates it, IF sees the pre-update value.
- o_br_un = ~i_ex_funct3[1]. It is driven whenever i_ex_is_br, otherwise 1.
- Direction decode, taken when:
  - 000: i_br_equal
  - 001: ~i_br_equal
  - 100, 110: i_br_less
  - 101, 111: ~i_br_less
  - 010, 011: illegal; not taken, no table update, no count.
- Jumps: JAL and JALR give o_ex_taken = 1.
- Resolution applies only when i_ex_valid & ~i_stall; otherwise o_redirect = 00, o_flush = 0, and no state changes. A held EX instruction resolves in the first unstalled cycle.
- Conditional branch redirect:
  - mispredict = taken ^ i_ex_pred_taken
  - taken & ~pred gives redirect 01
  - ~taken & pred gives redirect 10
  - o_flush = mispredict.
- JAL: redirect 01 and flush when ~i_ex_pred_taken, else none.
- JALR: always redirect 01 and flush, since the target is not predicted.
- Priority: if more than one of is_br, is_jal, is_jalr is set, JALR > JAL > branch.
- Table update: at the clock edge after a resolving legal conditional branch.
  - The entry at idx(i_ex_pc) increments if taken, decrements if not.
  - It saturates at 2'b11 and 2'b00.
  - Jumps never update the table.
- Counters:
  - o_br_count increments on each resolving legal conditional branch.
  - o_mispred_count increments when that branch also mispredicts.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Counters and the table are registered; all other outputs are combinational from current inputs and state.

Test Plan:
- Reset check: assert i_reset mid-run with entry 5 = 2'b11 and counts nonzero. Required: all entries read 01, both counts 0, o_if_pred_taken = 0 for all PCs, immediately and with no clock.
- BLT signed:
  - Stimulus: funct3 = 100, less = 1, pred = 0, pc = 0x14.
  - Required: o_br_un = 1, taken = 1, redirect 01, flush = 1.
  - Next cycle: entry 5 = 10, br_count = 1, mispred_count = 1.
- BGEU:
  - Stimulus: funct3 = 111, less = 0, pred = 1.
  - Required: o_br_un = 0, taken = 1, redirect 00, flush = 0, mispred_count unchanged.
- Saturation: resolve 4 taken BEQ at pc 0x40. Required: entry 0 goes 01→10→11→11; pred for 0x40 becomes 1 after the first update. Then 4 not-taken: entry goes 11→10→01→00→00.
- Stall and jumps:
  - Mispredicted BNE with i_stall = 1 for 3 cycles: redirect 00, no update. It resolves with flush on the cycle stall drops.
  - JALR with pred = 1: redirect 01, flush = 1.
  - JAL with pred = 1: no redirect, table untouched.
- Same-cycle read/write and illegal funct3:
  - Stimulus: IF pc = EX pc = 0x8 with the entry at 01, EX taken.
  - Required: IF sees pred 0 this cycle and 1 next cycle.
  - funct3 = 010: not taken, no count or update.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch decode, resolution, misprediction redirect and 2-bit BHT predictor
module branch_ctrl #(
   parameter int BHT_DEPTH = 16,
   parameter int IDX_LSB   = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_if_pc,
   output logic        o_if_pred_taken,
   input  logic        i_ex_valid,
   input  logic [31:0] i_ex_pc,
   input  logic        i_ex_is_br,
   input  logic        i_ex_is_jal,
   input  logic        i_ex_is_jalr,
   input  logic [2:0]  i_ex_funct3,
   input  logic        i_ex_pred_taken,
   input  logic        i_stall,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_br_un,
   output logic        o_ex_taken,
   output logic [1:0]  o_redirect,
   output logic        o_flush,
   output logic [31:0] o_br_count,
   output logic [31:0] o_mispred_count
);
   localparam int IW = $clog2(BHT_DEPTH);

   logic [1:0]    bht_q [BHT_DEPTH];
   logic [1:0]    ent, ent_d;
   logic [31:0]   br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   logic [IW-1:0] if_idx, ex_idx;
   logic          resolve, legal, dir, br_sel, jal_sel, mispred, br_upd;

   assign if_idx          = i_if_pc[IDX_LSB +: IW];
   assign ex_idx          = i_ex_pc[IDX_LSB +: IW];
   assign o_if_pred_taken = bht_q[if_idx][1];
   assign o_br_count      = br_cnt_q;
   assign o_mispred_count = mis_cnt_q;

   // decode direction, pick the winning control-flow kind (JALR > JAL > branch) and form redirect/flush
   always_comb begin
      legal      = i_ex_funct3[2:1] != 2'b01;
      dir        = i_ex_funct3[2] ? (i_br_less ^ i_ex_funct3[0]) : (i_br_equal ^ i_ex_funct3[0]);
      jal_sel    = i_ex_is_jal & ~i_ex_is_jalr;
      br_sel     = i_ex_is_br & ~i_ex_is_jal & ~i_ex_is_jalr & legal;
      resolve    = i_ex_valid & ~i_stall;
      o_ex_taken = i_ex_is_jalr | i_ex_is_jal | (br_sel & dir);
      mispred    = br_sel & (dir ^ i_ex_pred_taken);
      br_upd     = resolve & br_sel;
      o_flush    = resolve & (i_ex_is_jalr | (jal_sel & ~i_ex_pred_taken) | mispred);
      o_redirect = ~o_flush ? 2'b00 : (br_sel & ~dir) ? 2'b10 : 2'b01;
      o_br_un    = i_ex_is_br ? ~i_ex_funct3[1] : 1'b1;
      ent        = bht_q[ex_idx];
      ent_d      = dir ? ((ent == 2'b11) ? ent : ent + 2'd1) : ((ent == 2'b00) ? ent : ent - 2'd1);
      br_cnt_d   = br_cnt_q + {31'd0, br_upd & ~&br_cnt_q};
      mis_cnt_d  = mis_cnt_q + {31'd0, br_upd & mispred & ~&mis_cnt_q};
   end

   // predictor table: trained only by resolving legal conditional branches
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < BHT_DEPTH; k++) bht_q[k] <= 2'b01;
      end else if (br_upd) begin
         bht_q[ex_idx] <= ent_d;
      end
   end

   // saturating statistics counters
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: randomized + directed check of branch_ctrl against a behavioural model
module tb_branch_ctrl;
   logic        i_clk = 0, i_reset;
   logic [31:0] i_if_pc, i_ex_pc;
   logic        i_ex_valid, i_ex_is_br, i_ex_is_jal, i_ex_is_jalr, i_ex_pred_taken, i_stall, i_br_less, i_br_equal;
   logic [2:0]  i_ex_funct3;
   logic        o_if_pred_taken, o_br_un, o_ex_taken, o_flush;
   logic [1:0]  o_redirect;
   logic [31:0] o_br_count, o_mispred_count;

   int compared = 0, mismatched = 0;
   int bht [16];
   longint bc, mc;

   branch_ctrl #(.BHT_DEPTH(16), .IDX_LSB(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc), .o_if_pred_taken(o_if_pred_taken),
      .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_is_br(i_ex_is_br), .i_ex_is_jal(i_ex_is_jal),
      .i_ex_is_jalr(i_ex_is_jalr), .i_ex_funct3(i_ex_funct3), .i_ex_pred_taken(i_ex_pred_taken),
      .i_stall(i_stall), .i_br_less(i_br_less), .i_br_equal(i_br_equal), .o_br_un(o_br_un),
      .o_ex_taken(o_ex_taken), .o_redirect(o_redirect), .o_flush(o_flush),
      .o_br_count(o_br_count), .o_mispred_count(o_mispred_count));

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mtaken(input logic [2:0] f3, input logic less, input logic eq);
      case (f3)
         3'b000: return eq;
         3'b001: return !eq;
         3'b100, 3'b110: return less;
         3'b101, 3'b111: return !less;
         default: return 0;
      endcase
   endfunction

   function automatic bit mlegal(input logic [2:0] f3);
      return f3 != 3'b010 && f3 != 3'b011;
   endfunction

   // reference model state update
   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         foreach (bht[k]) bht[k] = 1;
         bc = 0;
         mc = 0;
      end else if (i_ex_valid && !i_stall && i_ex_is_br && !i_ex_is_jal && !i_ex_is_jalr && mlegal(i_ex_funct3)) begin
         int idx;
         bit t;
         idx = (i_ex_pc >> 2) % 16;
         t = mtaken(i_ex_funct3, i_br_less, i_br_equal);
         bht[idx] = t ? ((bht[idx] < 3) ? bht[idx] + 1 : 3) : ((bht[idx] > 0) ? bht[idx] - 1 : 0);
         if (bc < 64'hFFFF_FFFF) bc++;
         if (t != i_ex_pred_taken && mc < 64'hFFFF_FFFF) mc++;
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge i_clk) begin
      bit res, t, jr, jl, br, lg, e_taken;
      logic [1:0] e_red;
      jr = i_ex_is_jalr;
      jl = i_ex_is_jal && !jr;
      br = i_ex_is_br && !i_ex_is_jal && !jr;
      lg = mlegal(i_ex_funct3);
      t  = mtaken(i_ex_funct3, i_br_less, i_br_equal);
      res = i_ex_valid && !i_stall;
      e_taken = jr || i_ex_is_jal || (br && lg && t);
      if (!res) e_red = 0;
      else if (jr) e_red = 1;
      else if (jl) e_red = i_ex_pred_taken ? 2'd0 : 2'd1;
      else if (br && lg) e_red = (t && !i_ex_pred_taken) ? 2'd1 : (!t && i_ex_pred_taken) ? 2'd2 : 2'd0;
      else e_red = 0;
      chk("pred", {31'd0, o_if_pred_taken}, {31'd0, bht[(i_if_pc >> 2) % 16] >= 2});
      chk("br_un", {31'd0, o_br_un}, {31'd0, i_ex_is_br ? !i_ex_funct3[1] : 1'b1});
      chk("taken", {31'd0, o_ex_taken}, {31'd0, e_taken});
      chk("redirect", {30'd0, o_redirect}, {30'd0, e_red});
      chk("flush", {31'd0, o_flush}, {31'd0, e_red != 0});
      chk("br_count", o_br_count, bc[31:0]);
      chk("mispred_count", o_mispred_count, mc[31:0]);
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic br, jal, jalr,
                        input logic [2:0] f3, input logic pred, stall, less, eq);
      i_ex_valid = v; i_ex_pc = pc; i_ex_is_br = br; i_ex_is_jal = jal; i_ex_is_jalr = jalr;
      i_ex_funct3 = f3; i_ex_pred_taken = pred; i_stall = stall; i_br_less = less; i_br_equal = eq;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
   endtask

   bit tk [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
   bit ep [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};

   initial begin
      i_reset = 1;
      i_if_pc = 0;
      idle();
      repeat (2) @(posedge i_clk);
      #1 i_reset = 0;
      chk("rst_br_count", o_br_count, 0);
      chk("rst_mispred", o_mispred_count, 0);
      // BLT signed, mispredicted taken
      i_if_pc = 32'h14;
      drive(1, 32'h14, 1, 0, 0, 3'b100, 0, 0, 1, 0);
      #2;
      chk("blt_br_un", {31'd0, o_br_un}, 1);
      chk("blt_taken", {31'd0, o_ex_taken}, 1);
      chk("blt_redirect", {30'd0, o_redirect}, 1);
      chk("blt_flush", {31'd0, o_flush}, 1);
      chk("blt_pred_pre", {31'd0, o_if_pred_taken}, 0);
      step(); idle(); #2;
      chk("blt_pred_post", {31'd0, o_if_pred_taken}, 1);
      chk("blt_br_count", o_br_count, 1);
      chk("blt_mispred", o_mispred_count, 1);
      // BGEU correctly predicted taken
      drive(1, 32'h20, 1, 0, 0, 3'b111, 1, 0, 0, 0);
      #2;
      chk("bgeu_br_un", {31'd0, o_br_un}, 0);
      chk("bgeu_taken", {31'd0, o_ex_taken}, 1);
      chk("bgeu_redirect", {30'd0, o_redirect}, 0);
      chk("bgeu_flush", {31'd0, o_flush}, 0);
      step(); idle(); #2;
      chk("bgeu_br_count", o_br_count, 2);
      chk("bgeu_mispred", o_mispred_count, 1);
      // counter saturation at both ends on entry 0
      i_if_pc = 32'h40;
      for (int i = 0; i < 9; i++) begin
         drive(1, 32'h40, 1, 0, 0, 3'b000, 0, 0, 0, tk[i]);
         step(); #1;
         chk($sformatf("sat_pred_%0d", i), {31'd0, o_if_pred_taken}, {31'd0, ep[i]});
      end
      idle(); #1;
      chk("sat_br_count", o_br_count, 11);
      chk("sat_mispred", o_mispred_count, 6);
      // stalled mispredicted BNE resolves only when the stall drops
      i_if_pc = 32'h70;
      drive(1, 32'h70, 1, 0, 0, 3'b001, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("stall_redirect", {30'd0, o_redirect}, 0);
         chk("stall_flush", {31'd0, o_flush}, 0);
         step();
      end
      chk("stall_br_count", o_br_count, 11);
      chk("stall_pred", {31'd0, o_if_pred_taken}, 0);
      i_stall = 0;
      #2;
      chk("unstall_redirect", {30'd0, o_redirect}, 1);
      chk("unstall_flush", {31'd0, o_flush}, 1);
      step(); idle(); #1;
      chk("unstall_br_count", o_br_count, 12);
      chk("unstall_mispred", o_mispred_count, 7);
      // jumps
      drive(1, 32'h80, 0, 0, 1, 3'b000, 1, 0, 0, 0);
      #2;
      chk("jalr_redirect", {30'd0, o_redirect}, 1);
      chk("jalr_flush", {31'd0, o_flush}, 1);
      step();
      drive(1, 32'h84, 0, 1, 0, 3'b000, 1, 0, 0, 0);
      #2;
      chk("jal_redirect", {30'd0, o_redirect}, 0);
      chk("jal_flush", {31'd0, o_flush}, 0);
      chk("jal_taken", {31'd0, o_ex_taken}, 1);
      step(); idle(); #1;
      chk("jump_br_count", o_br_count, 12);
      // same-cycle read/write of entry 2
      i_if_pc = 32'h8;
      drive(1, 32'h8, 1, 0, 0, 3'b000, 0, 0, 0, 1);
      #2;
      chk("same_pred_pre", {31'd0, o_if_pred_taken}, 0);
      step(); #1;
      chk("same_pred_post", {31'd0, o_if_pred_taken}, 1);
      // illegal funct3
      drive(1, 32'h30, 1, 0, 0, 3'b010, 1, 0, 1, 1);
      #2;
      chk("ill_taken", {31'd0, o_ex_taken}, 0);
      chk("ill_redirect", {30'd0, o_redirect}, 0);
      step(); idle(); #1;
      chk("ill_br_count", o_br_count, 13);
      chk("ill_mispred", o_mispred_count, 8);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc;
         pc = $urandom;
         i_if_pc = ($urandom_range(0, 3) == 0) ? pc : $urandom;
         drive($urandom_range(0, 9) != 0, pc, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
               $urandom_range(0, 11) == 0, 3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
               1'($urandom), 1'($urandom));
         step();
      end
      // drive entry 5 to 11, then reset asynchronously mid-cycle
      i_if_pc = 32'h14;
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h14, 1, 0, 0, 3'b100, 1, 0, 1, 0);
         step();
      end
      idle(); #1;
      chk("pre_rst_pred5", {31'd0, o_if_pred_taken}, 1);
      #1 i_reset = 1;
      #1;
      chk("arst_br_count", o_br_count, 0);
      chk("arst_mispred", o_mispred_count, 0);
      for (int i = 0; i < 64; i++) begin
         i_if_pc = 32'(i * 4);
         #1;
         chk($sformatf("arst_pred_%0d", i), {31'd0, o_if_pred_taken}, 0);
      end
      i_reset = 0;
      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
